// File: rtl/bcd_feeder_pkg.sv
// Shared types and constants for the BCD display feeder: FSM states, CPU
// register map, CTRL bit layout and the leading-zero mask helper.
package bcd_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      WRITE
   } state_t;

   localparam logic [1:0] VAL_LO = 2'd0;
   localparam logic [1:0] VAL_HI = 2'd1;
   localparam logic [1:0] CTRL   = 2'd2;
   localparam logic [1:0] STATUS = 2'd3;

   localparam int CTRL_LZB    = 7;
   localparam int CTRL_EN_HI  = 5;
   localparam logic [7:0] CTRL_WMASK = 8'hBF;

   localparam int NUM_DIGITS = 5;

   // Enables digit 0 up to the most significant nonzero digit; digit 0 stays on for zero.
   function automatic logic [5:0] lz_mask(input logic [19:0] bcd);
      int msd;
      logic [5:0] mask;
      msd = 0;
      for (int i = 1; i < NUM_DIGITS; i++)
         if (bcd[4*i +: 4] != 4'h0) msd = i;
      for (int i = 0; i < 6; i++)
         mask[i] = (i <= msd);
      return mask;
   endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Serial 16-bit to 5-digit double-dabble: loads on start, then one
// add-3/shift iteration per clock for 16 clocks.
module bin2bcd_iter
   import bcd_feeder_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] bin,
   output logic        done,
   output logic [19:0] bcd
);

   logic [15:0] shift;
   logic [18:0] acc;
   logic [18:0] adj;
   logic [3:0]  cnt;
   logic        active;

   // The top digit never reaches 5 before the final shift, so it needs no correction.
   always_comb begin
      adj = acc;
      for (int i = 0; i < NUM_DIGITS - 1; i++)
         if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
   end

   // bcd is the result of the iteration in progress, so it is final while done is high.
   assign bcd  = {adj, shift[15]};
   assign done = active && (cnt == 4'd15);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift  <= '0;
         acc    <= '0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (start) begin
         shift  <= bin;
         acc    <= '0;
         cnt    <= '0;
         active <= 1'b1;
      end else if (active) begin
         shift <= {shift[14:0], 1'b0};
         acc   <= bcd[18:0];
         cnt   <= cnt + 4'd1;
         if (cnt == 4'd15) active <= 1'b0;
      end
   end

endmodule

// File: rtl/bcd_display_feeder.sv
// 6502 bus peripheral: converts a 16-bit value to BCD and feeds the
// seven-segment register block with three digit-pair writes and an enable mask.
module bcd_display_feeder
   import bcd_feeder_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       rw,
   input  logic [1:0] addr,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       seg_cs,
   output logic       seg_rw,
   output logic [1:0] seg_addr,
   output logic [7:0] seg_data,
   output logic       busy
);

   state_t      state;
   logic [7:0]  val_lo;
   logic [7:0]  val_hi;
   logic [7:0]  ctrl;
   logic        pending;
   logic [19:0] digits;

   logic        cpu_wr;
   logic        val_hi_wr;
   logic        last_write;
   logic        conv_start;
   logic        conv_done;
   logic [15:0] conv_bin;
   logic [19:0] conv_bcd;
   logic [1:0]  next_addr;
   logic [7:0]  next_byte;
   logic [5:0]  en;

   assign cpu_wr     = cs && !rw;
   assign val_hi_wr  = cpu_wr && (addr == VAL_HI);
   assign last_write = (state == WRITE) && (seg_addr == 2'd3);

   // A VAL_HI write landing on the last write cycle is taken as the pending restart.
   assign conv_bin   = {val_hi_wr ? data_in : val_hi, val_lo};
   assign conv_start = (val_hi_wr && state == IDLE) || (last_write && (pending || val_hi_wr));

   bin2bcd_iter u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bin   (conv_bin),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_comb begin
      data_out = 8'h00;
      case (addr)
         VAL_LO:  data_out = val_lo;
         VAL_HI:  data_out = val_hi;
         CTRL:    data_out = ctrl;
         default: data_out = {6'b0, pending, busy};
      endcase
   end

   assign en = ctrl[CTRL_EN_HI:0] & (ctrl[CTRL_LZB] ? lz_mask(digits) : 6'h3F);
   assign next_addr = seg_addr + 2'd1;

   always_comb begin
      next_byte = digits[7:0];
      case (next_addr)
         2'd1:    next_byte = digits[15:8];
         2'd2:    next_byte = {4'h0, digits[19:16]};
         2'd3:    next_byte = {2'b00, en};
         default: next_byte = digits[7:0];
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values; reset clears everything asynchronously, including seg_cs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         val_lo  <= '0;
         val_hi  <= '0;
         ctrl    <= '0;
         pending <= 1'b0;
      end else begin
         if (cpu_wr) begin
            case (addr)
               VAL_LO:  val_lo <= data_in;
               VAL_HI:  val_hi <= data_in;
               CTRL:    ctrl   <= data_in & CTRL_WMASK;
               default: ;
            endcase
         end
         if (conv_start)
            pending <= 1'b0;
         else if (val_hi_wr && state != IDLE)
            pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         seg_cs   <= 1'b0;
         seg_rw   <= 1'b1;
         seg_addr <= 2'd0;
         seg_data <= 8'h00;
         digits   <= '0;
      end else begin
         seg_cs <= 1'b0;
         seg_rw <= 1'b1;
         case (state)
            IDLE: begin
               if (conv_start) begin
                  state <= CONVERT;
                  busy  <= 1'b1;
               end
            end
            CONVERT: begin
               if (conv_done) begin
                  state    <= WRITE;
                  digits   <= conv_bcd;
                  seg_cs   <= 1'b1;
                  seg_rw   <= 1'b0;
                  seg_addr <= 2'd0;
                  seg_data <= conv_bcd[7:0];
               end
            end
            WRITE: begin
               if (last_write) begin
                  if (conv_start) begin
                     state <= CONVERT;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  seg_cs   <= 1'b1;
                  seg_rw   <= 1'b0;
                  seg_addr <= next_addr;
                  seg_data <= next_byte;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
